// File: rtl/md_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers and a registered
// move-from write-back port feeding the register file.
module md_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            mf_req,
    input  logic            mf_sel,
    input  logic [4:0]      mf_reg,
    output logic            busy,
    output logic            done,
    output logic            stall,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            wb_en,
    output logic [4:0]      wb_reg,
    output logic [XLEN-1:0] wb_data
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t              r_state;
    logic [4:0]          r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [XLEN-1:0]     r_hi;
    logic [XLEN-1:0]     r_lo;
    logic                r_wb_en;
    logic [4:0]          r_wb_reg;
    logic [XLEN-1:0]     r_wb_data;

    logic                r_is_div;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [XLEN-1:0]     r_div;
    logic [XLEN-1:0]     r_src_a;
    logic [2*XLEN-1:0]   r_acc;

    logic                w_accept;
    logic                w_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;
    logic [XLEN:0]       w_mul_sum;
    logic [XLEN+1:0]     w_trial;
    logic                w_div_ok;
    logic [XLEN-1:0]     w_rem_next;
    logic [2*XLEN-1:0]   w_step;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quot;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fix_hi;
    logic [XLEN-1:0]     w_fix_lo;

    // Ops 00/10 are signed; abs(0x80000000) wraps to itself and is used as unsigned.
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & src_a[XLEN-1];
    assign w_b_neg  = w_signed & src_b[XLEN-1];
    assign w_abs_a  = w_a_neg ? -src_a : src_a;
    assign w_abs_b  = w_b_neg ? -src_b : src_b;

    // Multiply: acc = {partial, multiplier}; add into the top half, shift right.
    // Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_div} : '0);
    assign w_trial    = {1'b0, r_acc[2*XLEN-1:XLEN-1]} - {2'b00, r_div};
    assign w_div_ok   = ~w_trial[XLEN+1];
    assign w_rem_next = w_div_ok ? w_trial[XLEN-1:0] : r_acc[2*XLEN-2:XLEN-1];
    assign w_step     = r_is_div ? {w_rem_next, r_acc[XLEN-2:0], w_div_ok}
                                 : {w_mul_sum, r_acc[XLEN-1:1]};

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quot = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_hi = w_prod[2*XLEN-1:XLEN];
        w_fix_lo = w_prod[XLEN-1:0];
        if (r_is_div) begin
            if (r_div == '0) begin
                w_fix_hi = r_src_a;
                w_fix_lo = '1;
            end else begin
                w_fix_hi = w_rem;
                w_fix_lo = w_quot;
            end
        end
    end

    // NOTE: operand and accumulator registers carry no reset; they are always
    // reloaded on accept before being read, so resetting them buys nothing.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_div <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div    <= w_abs_b;
            r_src_a  <= src_a;
            r_acc    <= {{XLEN{1'b0}}, w_abs_a};
        end else if (r_state == S_CALC) begin
            r_acc <= w_step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_wb_en   <= 1'b0;
            r_wb_reg  <= '0;
            r_wb_data <= '0;
        end else begin
            r_done  <= 1'b0;
            r_wb_en <= 1'b0;
            // Move-from reads the HI/LO visible this cycle, before any update.
            if (mf_req && !r_busy) begin
                r_wb_en   <= (mf_reg != 5'd0);
                r_wb_reg  <= mf_reg;
                r_wb_data <= mf_sel ? r_hi : r_lo;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_CALC;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign stall   = mf_req & r_busy;
    assign hi      = r_hi;
    assign lo      = r_lo;
    assign wb_en   = r_wb_en;
    assign wb_reg  = r_wb_reg;
    assign wb_data = r_wb_data;

endmodule
